led_matrix_scroll_ctrl: RTL and testbench
=========================================

// Module: led_matrix_scroll_ctrl
// PURPOSE
//   Parametrised column-scan controller for an ROWS x COLS LED matrix. It shows a
//   window of COLS columns from a MSG_COLS-wide message bitmap.
//   Four modes: static, scroll-left, scroll-right, blink.
//   It replaces the fixed 5x7 divider, column ring and row-register chain with a
//   single block: built-in prescaler, anti-ghost blanking, tear-free message load.
// PARAMETERS
//   ROWS            5      matrix rows (row outputs)
//   COLS            7      matrix columns (scanned, one active at a time)
//   MSG_COLS        16     message width in columns; >= 2
//   SCAN_DIV        50000  clk cycles per column slot; >= BLANK_CYC+1
//   BLANK_CYC       500    cycles at start of each slot with display blanked; >= 0
//   FRAMES_PER_STEP 10     full frames per scroll/blink step; >= 1
// PORTS
//   clk        in   1                  system clock (50 MHz board clock)
//   rst_n      in   1                  asynchronous reset, active low
//   mode       in   2                  00 static, 01 scroll left, 10 scroll right, 11 blink
//   restart    in   1                  sync: clear offset/counters, start new frame
//   msg_data   in   ROWS*MSG_COLS      bit [r*MSG_COLS+m] = row r, message column m
//   col_n      out  COLS               column drive, active low (at most one bit 0)
//   row        out  ROWS               row drive, active high
//   frame_tick out  1                  1-cycle pulse at each frame end
//   step_tick  out  1                  1-cycle pulse at each step
//   scroll_pos out  $clog2(MSG_COLS)   current window offset
// BEHAVIOUR
//   - Reset (async assert): all counters and offset = 0; shadow bitmap = 0.
//     Reset output values: mode_q = 00, blink_phase = 0, col_n = all 1, row = 0,
//     both ticks = 0, scroll_pos = 0.
//   - Edges are numbered from 1 at the first rising edge after rst_n deassertion
//     or after restart. Slot s covers edges s*SCAN_DIV+1 .. (s+1)*SCAN_DIV.
//     Column index = s mod COLS.
//   - Within a slot, at edge j (1..SCAN_DIV) the outputs are registered as follows:
//     j <= BLANK_CYC: col_n = all 1, row = 0.
//     j >  BLANK_CYC: col_n = ~(1<<c), row[r] = shadow[r*MSG_COLS + ((offset+c) mod MSG_COLS)].
//   - Frame end is the edge closing slot COLS-1 (edge COLS*SCAN_DIV of the frame).
//     On that edge:
//       frame_tick = 1 for exactly one cycle;
//       shadow <= msg_data (only sample point, so no tearing mid-frame);
//       mode_q <= mode (mode changes only take effect here);
//       frame counter increments.
//   - Step: a frame end where the frame counter is at FRAMES_PER_STEP-1.
//     The frame counter wraps to 0 and step_tick = 1 for one cycle, coincident
//     with frame_tick. The step action uses the mode_q value held before this edge:
//       00: offset held.
//       01: offset <= (offset+1) mod MSG_COLS; wraps MSG_COLS-1 -> 0.
//       10: offset <= (offset-1) mod MSG_COLS; wraps 0 -> MSG_COLS-1.
//       11: offset held; blink_phase toggles.
//   - Blink: while mode_q = 11 and blink_phase = 1, the whole frame is blanked.
//     Blanked means col_n all 1 and row 0; scan timing is unchanged.
//     Leaving mode 11 clears blink_phase at that frame end.
//   - Switching to static or blink freezes the current offset; there is no jump to 0.
//   - restart = 1: on the next edge, offset, frame/slot/prescaler counters and
//     blink_phase go to 0, and the outputs blank. Edge numbering then restarts.
//     restart wins over a simultaneous frame end or step; no ticks pulse on that edge.
//     restart does not reload the shadow bitmap.
//   - First frame after reset shows a blank bitmap, because the shadow is 0 until the
//     first frame end.
//   - rst_n asserted mid-slot or mid-frame: everything returns to reset values at once.
// TESTING  (ROWS=5 COLS=7 MSG_COLS=16 SCAN_DIV=4 BLANK_CYC=1 FRAMES_PER_STEP=2)
//   1. Reset release, mode=00, msg_data bits [15:0]=16'h00FF, other rows 0
//      -> frame 1 row=0 throughout; edge 2 col_n=7'b1111110; edge 5 col_n=all 1;
//         edge 6 col_n=7'b1111101; frame_tick at edge 28.
//      -> frame 2, col 0: after edge 30, row=5'b00001.
//   2. mode=01 held -> step_tick at edges 56, 112, ...;
//      scroll_pos 0->1->2 ... 15->0; col c shows msg column (pos+c) mod 16.
//   3. mode=10 from reset -> scroll_pos 0 -> 15 at edge 56, 14 at edge 112.
//   4. mode=11 -> after each step_tick, alternate 56-edge periods are fully blanked:
//      col_n all 1, row 0, frame_tick still pulses.
//   5. Mode 01 -> 00 switch mid-frame at scroll_pos=3 -> change applies at next
//      frame end; the step at the first step edge still advances 3->4 (old mode);
//      4 is then held.
//   6. restart asserted on a step edge -> no ticks, scroll_pos=0, col_n all 1 next
//      cycle. Then async rst_n pulse mid-slot -> all outputs at reset values
//      immediately.

Source files
------------

// File: rtl/led_matrix_scroll_ctrl.sv
// Column-scan controller for a ROWS x COLS LED matrix.
// It shows a scrolling or blinking window of a wider message bitmap.
module led_matrix_scroll_ctrl #(
   parameter int ROWS            = 5,
   parameter int COLS            = 7,
   parameter int MSG_COLS        = 16,
   parameter int SCAN_DIV        = 50000,
   parameter int BLANK_CYC       = 500,
   parameter int FRAMES_PER_STEP = 10
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [1:0]                  mode,
   input  logic                        restart,
   input  logic [ROWS*MSG_COLS-1:0]    msg_data,
   output logic [COLS-1:0]             col_n,
   output logic [ROWS-1:0]             row,
   output logic                        frame_tick,
   output logic                        step_tick,
   output logic [$clog2(MSG_COLS)-1:0] scroll_pos
);

   localparam int OW = $clog2(MSG_COLS);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

   typedef enum logic [1:0] {
      M_STATIC = 2'b00,
      M_LEFT   = 2'b01,
      M_RIGHT  = 2'b10,
      M_BLINK  = 2'b11
   } mode_e;

   logic [PW-1:0]                 pre_q, pre_d;
   logic [CW-1:0]                 col_q, col_d;
   logic [FW-1:0]                 frm_q, frm_d;
   logic [OW-1:0]                 off_q, off_d;
   logic                          blink_q, blink_d;
   mode_e                         mode_q, mode_d;
   logic [ROWS-1:0][MSG_COLS-1:0] shadow_q, shadow_d;
   logic [COLS-1:0]               col_n_q, col_n_d;
   logic [ROWS-1:0]               row_q, row_d;
   logic                          ftick_q, ftick_d;
   logic                          stick_q, stick_d;

   logic          slot_end;
   logic          frame_end;
   logic          step;
   logic          lit;
   logic [OW-1:0] mcol;

   assign slot_end  = (pre_q == PW'(SCAN_DIV - 1));
   assign frame_end = slot_end && (col_q == CW'(COLS - 1));
   assign step      = frame_end && (frm_q == FW'(FRAMES_PER_STEP - 1));
   assign mcol      = OW'((32'(off_q) + 32'(col_q)) % MSG_COLS);

   // Lit only past the anti-ghost window and outside a blink-off frame
   assign lit = (int'(pre_q) >= BLANK_CYC) &&
                !((mode_q == M_BLINK) && blink_q);

   always_comb begin
      pre_d    = slot_end ? '0 : pre_q + PW'(1);
      col_d    = col_q;
      frm_d    = frm_q;
      off_d    = off_q;
      blink_d  = blink_q;
      mode_d   = mode_q;
      shadow_d = shadow_q;
      col_n_d  = '1;
      row_d    = '0;
      ftick_d  = frame_end;
      stick_d  = step;

      if (slot_end) begin
         col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
      end

      if (lit) begin
         col_n_d = ~(COLS'(1) << col_q);
         for (int r = 0; r < ROWS; r++) begin
            row_d[r] = shadow_q[r][mcol];
         end
      end

      if (frame_end) begin
         shadow_d = msg_data;
         mode_d   = mode_e'(mode);
         frm_d    = step ? '0 : frm_q + FW'(1);
         if (step) begin
            unique case (mode_q)
               M_STATIC: off_d = off_q;
               M_LEFT:
                  off_d = (off_q == OW'(MSG_COLS - 1)) ?
                          '0 : off_q + OW'(1);
               M_RIGHT:
                  off_d = (off_q == '0) ?
                          OW'(MSG_COLS - 1) : off_q - OW'(1);
               M_BLINK: blink_d = ~blink_q;
            endcase
         end
         if (mode_e'(mode) != M_BLINK) begin
            blink_d = 1'b0;
         end
      end

      // Restart overrides any frame end or step on the same edge
      if (restart) begin
         pre_d    = '0;
         col_d    = '0;
         frm_d    = '0;
         off_d    = '0;
         blink_d  = 1'b0;
         mode_d   = mode_q;
         shadow_d = shadow_q;
         col_n_d  = '1;
         row_d    = '0;
         ftick_d  = 1'b0;
         stick_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q    <= '0;
         col_q    <= '0;
         frm_q    <= '0;
         off_q    <= '0;
         blink_q  <= 1'b0;
         mode_q   <= M_STATIC;
         shadow_q <= '0;
         col_n_q  <= '1;
         row_q    <= '0;
         ftick_q  <= 1'b0;
         stick_q  <= 1'b0;
      end else begin
         pre_q    <= pre_d;
         col_q    <= col_d;
         frm_q    <= frm_d;
         off_q    <= off_d;
         blink_q  <= blink_d;
         mode_q   <= mode_d;
         shadow_q <= shadow_d;
         col_n_q  <= col_n_d;
         row_q    <= row_d;
         ftick_q  <= ftick_d;
         stick_q  <= stick_d;
      end
   end

   assign col_n      = col_n_q;
   assign row        = row_q;
   assign frame_tick = ftick_q;
   assign step_tick  = stick_q;
   assign scroll_pos = off_q;

endmodule

// File: tb/tb_led_matrix_scroll_ctrl.sv
// Directed bench for led_matrix_scroll_ctrl with a small scan geometry.
// Edge numbers are counted from 1 after each reset release or restart.
module tb_led_matrix_scroll_ctrl;

   logic        clk;
   logic        rst_n;
   logic [1:0]  mode;
   logic        restart;
   logic [79:0] msg_data;
   logic [6:0]  col_n;
   logic [4:0]  row;
   logic        frame_tick;
   logic        step_tick;
   logic [3:0]  scroll_pos;

   int checks = 0;
   int errors = 0;
   int e = 0;

   led_matrix_scroll_ctrl #(
      .ROWS(5), .COLS(7), .MSG_COLS(16),
      .SCAN_DIV(4), .BLANK_CYC(1), .FRAMES_PER_STEP(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .restart(restart),
      .msg_data(msg_data), .col_n(col_n), .row(row),
      .frame_tick(frame_tick), .step_tick(step_tick),
      .scroll_pos(scroll_pos)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic goto(input int k);
      while (e < k) begin
         @(posedge clk);
         e++;
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      chk("rst_col_n", 32'(col_n), 32'h7F);
      chk("rst_row", 32'(row), 32'h0);
      chk("rst_ticks", {30'd0, frame_tick, step_tick}, 32'h0);
      chk("rst_pos", 32'(scroll_pos), 32'h0);
      #1;
      rst_n = 1'b1;
      e = 0;
   endtask

   initial begin
      rst_n    = 1'b1;
      mode     = 2'b00;
      restart  = 1'b0;
      msg_data = '0;
      #1;

      // 1: static mode, first frame blank, scan timing
      msg_data[15:0] = 16'h00FF;
      do_reset();
      goto(1);  chk("t1_e1_col", 32'(col_n), 32'h7F);
      goto(2);  chk("t1_e2_col", 32'(col_n), 32'h7E);
      chk("t1_e2_row", 32'(row), 32'h0);
      goto(5);  chk("t1_e5_col", 32'(col_n), 32'h7F);
      goto(6);  chk("t1_e6_col", 32'(col_n), 32'h7D);
      chk("t1_e6_row", 32'(row), 32'h0);
      goto(27); chk("t1_e27_ft", 32'(frame_tick), 32'h0);
      goto(28); chk("t1_e28_ft", 32'(frame_tick), 32'h1);
      chk("t1_e28_st", 32'(step_tick), 32'h0);
      chk("t1_e28_col", 32'(col_n), 32'h3F);
      goto(29); chk("t1_e29_ft", 32'(frame_tick), 32'h0);
      chk("t1_e29_col", 32'(col_n), 32'h7F);
      goto(30); chk("t1_e30_row", 32'(row), 32'h01);
      chk("t1_e30_col", 32'(col_n), 32'h7E);

      // 2: scroll left, full wrap of the offset
      mode = 2'b01;
      msg_data = '0;
      msg_data[15:0]  = 16'h0001;
      msg_data[31:16] = 16'h8000;
      do_reset();
      goto(30);  chk("t2_e30_row", 32'(row), 32'h01);
      goto(55);  chk("t2_e55_st", 32'(step_tick), 32'h0);
      goto(56);  chk("t2_e56_st", 32'(step_tick), 32'h1);
      chk("t2_e56_ft", 32'(frame_tick), 32'h1);
      chk("t2_e56_pos", 32'(scroll_pos), 32'h1);
      goto(58);  chk("t2_e58_row", 32'(row), 32'h0);
      goto(112); chk("t2_e112_st", 32'(step_tick), 32'h1);
      chk("t2_e112_pos", 32'(scroll_pos), 32'h2);
      goto(840); chk("t2_e840_pos", 32'(scroll_pos), 32'hF);
      goto(842); chk("t2_e842_row", 32'(row), 32'h02);
      goto(846); chk("t2_e846_row", 32'(row), 32'h01);
      goto(895); chk("t2_e895_pos", 32'(scroll_pos), 32'hF);
      goto(896); chk("t2_e896_pos", 32'(scroll_pos), 32'h0);
      chk("t2_e896_st", 32'(step_tick), 32'h1);

      // 3: scroll right wraps 0 -> 15
      mode = 2'b10;
      do_reset();
      goto(56);  chk("t3_e56_pos", 32'(scroll_pos), 32'hF);
      goto(58);  chk("t3_e58_row", 32'(row), 32'h02);
      goto(112); chk("t3_e112_pos", 32'(scroll_pos), 32'hE);

      // 4: blink alternates visible and blanked step periods
      mode = 2'b11;
      msg_data = '0;
      msg_data[15:0] = 16'h00FF;
      do_reset();
      goto(30);  chk("t4_e30_row", 32'(row), 32'h01);
      goto(56);  chk("t4_e56_st", 32'(step_tick), 32'h1);
      goto(58);  chk("t4_e58_col", 32'(col_n), 32'h7F);
      chk("t4_e58_row", 32'(row), 32'h0);
      goto(84);  chk("t4_e84_ft", 32'(frame_tick), 32'h1);
      chk("t4_e84_col", 32'(col_n), 32'h7F);
      goto(114); chk("t4_e114_col", 32'(col_n), 32'h7E);
      chk("t4_e114_row", 32'(row), 32'h01);
      chk("t4_e114_pos", 32'(scroll_pos), 32'h0);
      goto(170); chk("t4_e170_col", 32'(col_n), 32'h7F);

      // 5: left -> static mid-frame; old mode still steps once
      mode = 2'b01;
      do_reset();
      goto(200); chk("t5_e200_pos", 32'(scroll_pos), 32'h3);
      mode = 2'b00;
      goto(224); chk("t5_e224_pos", 32'(scroll_pos), 32'h4);
      chk("t5_e224_st", 32'(step_tick), 32'h1);
      goto(280); chk("t5_e280_pos", 32'(scroll_pos), 32'h4);
      goto(336); chk("t5_e336_pos", 32'(scroll_pos), 32'h4);

      // 6: restart on a step edge, then async reset mid-slot
      mode = 2'b01;
      msg_data = '0;
      msg_data[15:0] = 16'h0002;
      do_reset();
      goto(55);
      restart = 1'b1;
      goto(56);
      chk("t6_rs_st", 32'(step_tick), 32'h0);
      chk("t6_rs_ft", 32'(frame_tick), 32'h0);
      chk("t6_rs_pos", 32'(scroll_pos), 32'h0);
      chk("t6_rs_col", 32'(col_n), 32'h7F);
      restart = 1'b0;
      e = 0;
      goto(2);  chk("t6_e2_col", 32'(col_n), 32'h7E);
      chk("t6_e2_row", 32'(row), 32'h0);
      goto(6);  chk("t6_e6_row", 32'(row), 32'h01);
      goto(56); chk("t6_e56_pos", 32'(scroll_pos), 32'h1);
      goto(58); chk("t6_e58_row", 32'(row), 32'h01);
      rst_n = 1'b0;
      #1;
      chk("t6_ar_col", 32'(col_n), 32'h7F);
      chk("t6_ar_row", 32'(row), 32'h0);
      chk("t6_ar_pos", 32'(scroll_pos), 32'h0);
      chk("t6_ar_ticks", {30'd0, frame_tick, step_tick}, 32'h0);
      rst_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
